// File: rtl/serial_bit_tx_pkg.sv
// rtl/serial_bit_tx_pkg.sv - shared types and constants for the serial bit transmitter
package serial_bit_tx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_t;

  localparam logic TX_IDLE_LEVEL = 1'b0;

  // Counter width that never collapses to zero bits (HOLD=1 still needs a register)
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_bit_tx_if.sv
// rtl/serial_bit_tx_if.sv - load handshake (valid/ready/data) between word source and transmitter
interface serial_bit_tx_if #(
  parameter int WIDTH = 8
) ();

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);

endinterface

// File: rtl/serial_bit_tx_hold_counter.sv
// rtl/serial_bit_tx_hold_counter.sv - modulo-HOLD counter, wrap marks the last cycle of a bit
module hold_counter
  import serial_bit_tx_pkg::*;
#(
  parameter int HOLD = 2
) (
  input  logic CK,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic wrap
);

  localparam int HW = cnt_width(HOLD);
  localparam logic [HW-1:0] LAST = HW'(HOLD - 1);

  logic [HW-1:0] cnt;

  assign wrap = en && (cnt == LAST);

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || wrap) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + HW'(1);
    end
  end

endmodule

// File: rtl/serial_bit_tx.sv
// rtl/serial_bit_tx.sv - LSB-first serial transmitter, each bit held HOLD cycles on D
// Optional even-parity trailer bit: SERIAL_BIT_TX_PARITY_EN
module serial_bit_tx
  import serial_bit_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int HOLD  = 2
) (
  input  logic                  CK,
  input  logic                  reset,
  serial_bit_tx_if.slave        load,
  output logic                  D,
  output logic                  busy,
  output logic                  done
);

`ifdef SERIAL_BIT_TX_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int IW = $clog2(N + 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(N - 1);

  tx_state_t     state, state_nxt;
  logic [N-1:0]  shreg;
  logic [N-1:0]  capture;
  logic [IW-1:0] bit_idx;
  logic          accept;
  logic          wrap;
  logic          last_wrap;

`ifdef SERIAL_BIT_TX_PARITY_EN
  assign capture = {^load.load_data, load.load_data};
`else
  assign capture = load.load_data;
`endif

  assign accept    = (state == IDLE) && load.load_valid;
  assign last_wrap = wrap && (bit_idx == LAST_BIT);

  hold_counter #(
    .HOLD (HOLD)
  ) u_hold (
    .CK    (CK),
    .reset (reset),
    .clear (accept),
    .en    (state == SHIFT),
    .wrap  (wrap)
  );

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load.load_valid) state_nxt = SHIFT;
      SHIFT:   if (last_wrap)       state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load.load_ready = (state == IDLE);
    busy            = (state == SHIFT);
    D               = (state == SHIFT) ? shreg[0] : TX_IDLE_LEVEL;
  end

  // done is registered so it coincides with the first IDLE cycle, not the last bit
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      bit_idx <= '0;
      done    <= 1'b0;
    end else begin
      done <= last_wrap;
      if (accept) begin
        shreg   <= capture;
        bit_idx <= '0;
      end else if (wrap) begin
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_bit_tx.sv
// tb/tb_serial_bit_tx.sv - directed scoreboard bench for serial_bit_tx (WIDTH=8/HOLD=2 and WIDTH=1/HOLD=1)
module tb_serial_bit_tx;

`ifdef SERIAL_BIT_TX_PARITY_EN
  localparam int N_A = 9;
`else
  localparam int N_A = 8;
`endif
  localparam int HOLD_A = 2;

  logic CK;
  logic reset;
  logic a_d, a_busy, a_done;
  logic b_d, b_busy, b_done;
  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];

  serial_bit_tx_if #(.WIDTH(8)) a_if ();
  serial_bit_tx_if #(.WIDTH(1)) b_if ();

  serial_bit_tx #(.WIDTH(8), .HOLD(HOLD_A)) dut_a (
    .CK    (CK),
    .reset (reset),
    .load  (a_if),
    .D     (a_d),
    .busy  (a_busy),
    .done  (a_done)
  );

  serial_bit_tx #(.WIDTH(1), .HOLD(1)) dut_b (
    .CK    (CK),
    .reset (reset),
    .load  (b_if),
    .D     (b_d),
    .busy  (b_busy),
    .done  (b_done)
  );

  initial begin
    CK = 1'b0;
    #2;
    forever #5 CK = ~CK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame_a(input logic [7:0] w);
    logic [8:0] fr;
    fr = {^w, w};
    for (int i = 0; i < N_A; i++)
      for (int h = 0; h < HOLD_A; h++)
        exp_q.push_back(fr[i]);
  endtask

  task automatic start_a(input logic [7:0] w);
    a_if.load_valid = 1'b1;
    a_if.load_data  = w;
    push_frame_a(w);
  endtask

  task automatic drain_a(input string tag, input bit toggle, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      @(negedge CK);
      if (toggle) begin
        a_if.load_valid = 1'($urandom_range(0, 1));
        a_if.load_data  = 8'($urandom);
      end else begin
        a_if.load_valid = 1'b0;
      end
      chk({tag, "_d"}, a_d, exp_q.pop_front());
      chk({tag, "_busy"}, a_busy, 1'b1);
      chk({tag, "_ready"}, a_if.load_ready, 1'b0);
      chk({tag, "_done_low"}, a_done, 1'b0);
    end
  endtask

  task automatic end_a(input string tag);
    @(negedge CK);
    chk({tag, "_done"}, a_done, 1'b1);
    chk({tag, "_done_d"}, a_d, 1'b0);
    chk({tag, "_done_ready"}, a_if.load_ready, 1'b1);
    chk({tag, "_done_busy"}, a_busy, 1'b0);
  endtask

  task automatic idle_a(input string tag);
    @(negedge CK);
    chk({tag, "_idle_done"}, a_done, 1'b0);
    chk({tag, "_idle_busy"}, a_busy, 1'b0);
    chk({tag, "_idle_d"}, a_d, 1'b0);
  endtask

  initial begin
    reset           = 1'b1;
    a_if.load_valid = 1'b0;
    a_if.load_data  = '0;
    b_if.load_valid = 1'b0;
    b_if.load_data  = '0;

    #20;
    chk("rst_a_d", a_d, 1'b0);
    chk("rst_a_busy", a_busy, 1'b0);
    chk("rst_a_done", a_done, 1'b0);
    chk("rst_a_ready", a_if.load_ready, 1'b1);
    chk("rst_b_d", b_d, 1'b0);
    chk("rst_b_ready", b_if.load_ready, 1'b1);
    #15;
    reset = 1'b0;

    repeat (10) begin
      @(negedge CK);
      chk("post_rst_d", a_d, 1'b0);
      chk("post_rst_busy", a_busy, 1'b0);
      chk("post_rst_done", a_done, 1'b0);
      chk("post_rst_ready", a_if.load_ready, 1'b1);
    end

    start_a(8'hA5);
    drain_a("a5", 1'b0, exp_q.size());
    end_a("a5");
    idle_a("a5");

    start_a(8'hFF);
    drain_a("b2b_ff", 1'b1, exp_q.size());
    end_a("b2b_ff");
    start_a(8'h01);
    drain_a("b2b_01", 1'b0, exp_q.size());
    end_a("b2b_01");
    idle_a("b2b_01");

    b_if.load_valid = 1'b1;
    b_if.load_data  = 1'b1;
    @(negedge CK);
    b_if.load_valid = 1'b0;
    chk("w1_d", b_d, 1'b1);
    chk("w1_busy", b_busy, 1'b1);
    chk("w1_ready", b_if.load_ready, 1'b0);
    @(negedge CK);
    chk("w1_done", b_done, 1'b1);
    chk("w1_done_d", b_d, 1'b0);
    chk("w1_done_ready", b_if.load_ready, 1'b1);
    @(negedge CK);
    chk("w1_idle_done", b_done, 1'b0);
    chk("w1_idle_busy", b_busy, 1'b0);

    start_a(8'h0F);
    drain_a("mid", 1'b0, 3 * HOLD_A + 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_d", a_d, 1'b0);
    chk("mid_rst_busy", a_busy, 1'b0);
    chk("mid_rst_done", a_done, 1'b0);
    chk("mid_rst_ready", a_if.load_ready, 1'b1);
    exp_q.delete();
    #1;
    reset = 1'b0;
    repeat (3) idle_a("mid_after");

    start_a(8'h3C);
    drain_a("3c", 1'b0, exp_q.size());
    end_a("3c");
    idle_a("3c");

    start_a(8'h07);
    drain_a("par07", 1'b0, exp_q.size());
    end_a("par07");
    idle_a("par07");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_bit_tx.md
# serial_bit_tx

Synchronous serial bit transmitter that drives a single-bit data line `D` for downstream storage elements (D latch / D flip-flop exercises) and sampling logic. It accepts a parallel word over a valid/ready handshake and shifts it out LSB-first. Each bit is held for a fixed number of `CK` cycles. It replaces hand-written `D` stimulus sequences with a synthesizable, cycle-exact source that sits in front of the latch/flip-flop blocks of this chapter.

## Interface
Parameters:
- `WIDTH`, default 8: number of data bits per frame, at least 1.
- `HOLD`, default 2: number of `CK` cycles each bit is held on `D`, at least 1.

Ports:
- `CK`, input, 1: clock. All state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `load_valid`, input, 1: a word is offered on `load_data`.
- `load_ready`, output, 1: the block can accept a word.
- `load_data`, input, WIDTH: word to transmit. Sampled only at accept.
- `D`, output, 1: serial data line. Idle level is 0.
- `busy`, output, 1: a frame is in progress.
- `done`, output, 1: one-cycle pulse when a frame completes.

## Operation
- States are `IDLE` and `SHIFT`.
  - `IDLE`: `load_ready`=1, `D`=0, `busy`=0.
  - `SHIFT`: `load_ready`=0, `busy`=1.
- Accept occurs when `load_valid && load_ready` is sampled at a rising `CK` edge.
  - `load_data` is captured into the shift register, and the bit index and hold counter are cleared.
  - The state moves to `SHIFT`.
- In `SHIFT`, `D` is the current register LSB.
  - The hold counter counts 0..HOLD-1.
  - At HOLD-1 the register shifts right by one, the bit index increments, and the hold counter wraps to 0.
- After bit index N-1 has completed its HOLD cycles, the state returns to `IDLE` and `done`=1 for exactly that one cycle. N = WIDTH, or WIDTH+1 with parity (see Configuration).
- `load_valid` is ignored while in `SHIFT`. No queueing and no abort input.
- Reset values (asynchronous, immediate): state `IDLE`, `D`=0, `busy`=0, `done`=0, `load_ready`=1, counters 0, register 0.
- Reset mid-frame drops the word. `D` goes to 0 immediately with no partial completion and no `done` pulse.
- Counter widths: hold counter is $clog2(HOLD), minimum 1 bit; bit index is $clog2(N+1). Counter comparisons must not overflow for HOLD=1 or WIDTH=1.

## Timing
- Accept at edge k: first bit drives `D` from edge k to k+HOLD.
- Bit i is valid on `D` from edge k+i·HOLD to k+(i+1)·HOLD.
- `done`=1 and `D`=0 in the cycle following edge k+N·HOLD.
- Frame latency from accept to `done` is N·HOLD cycles.
- `load_ready` rises in the same cycle as `done`.
  - A word accepted at that edge starts the next frame.
  - Back-to-back frames therefore have exactly one idle cycle with `D`=0 between them.
- `done` and `load_ready` outputs are registered state decodes with no combinational path from `load_valid`.

## Configuration
- `SERIAL_BIT_TX_PARITY_EN`:
  - Defined: after the WIDTH data bits, one even-parity bit (XOR of the captured word) is held for HOLD cycles, so N = WIDTH+1.
  - Undefined: N = WIDTH, no parity logic is present, and ports are identical in both builds.

## Structure
- Package `serial_bit_tx_pkg` contains:
  - the state enum `tx_state_t` {IDLE, SHIFT};
  - the constant `TX_IDLE_LEVEL` = 1'b0.
- One sub-module, `hold_counter`, with inputs `CK`, `reset`, `clear`, `en` and output `wrap`. It is a modulo-HOLD counter and asserts `wrap` when at HOLD-1 with `en` high.
- The top level contains the FSM, the shift register, the bit index and the optional parity bit.

## Test plan
- Reset value check: assert `reset` for 35 ns. During reset `D`=0, `busy`=0, `done`=0, `load_ready`=1. Release it with `load_valid`=0: outputs stay at idle values for 10 cycles.
- Single frame, WIDTH=8, HOLD=2, word 8'hA5: `D` sequence is 1,1,0,0,1,1,0,0,0,0,1,1,0,0,1,1, one value per cycle. Then `done` pulses once at cycle 16 after accept and `D`=0.
- Back-to-back 8'hFF then 8'h01 with `load_valid` held high: the second accept happens in the `done` cycle. Exactly one `D`=0 cycle separates the frames. `load_valid` toggled during the frames causes no effect.
- HOLD=1, WIDTH=1, word 1'b1: `D`=1 for one cycle, `done` in the next cycle, with no counter overflow.
- Reset mid-frame: assert `reset` asynchronously between edges during bit 3 of 8'h0F. `D` and `busy` drop to 0 immediately, no `done` pulse, and the next accepted word 8'h3C transmits correctly.
- With `SERIAL_BIT_TX_PARITY_EN` defined, word 8'h07 is followed by parity bit 1 held for HOLD cycles. Frame latency is 9·HOLD cycles.
